// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the sum accumulator bank and its one-hot encoder.
package sum_accum_pkg;

  typedef enum logic {ACCUM, DRAIN} state_e;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned IDX_W     = 2;

  // Widest supported bank; the top slices this down to its own ACC_W.
  localparam int unsigned ACC_W_MAX = 32;
  localparam logic [ACC_W_MAX-1:0] SAT_MAX = '1;

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to index encoder with a validity flag for the bank select.
module onehot_enc
  import sum_accum_pkg::*;
(
  input  logic [NUM_BANKS-1:0] i_onehot,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_is_onehot
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (i_onehot[i]) o_idx = o_idx | IDX_W'(i);
    end
    o_is_onehot = $onehot(i_onehot);
  end

endmodule

// File: rtl/sum_accum_bank.sv
// Four-bank accumulator fed by the adder/decoder stage, drained serially on request.
// Define SUM_ACCUM_SAT_EN to make bank additions saturate instead of wrapping.
module sum_accum_bank
  import sum_accum_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    sum_in,
  input  logic [NUM_BANKS-1:0] sel_onehot,
  input  logic                 drain_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [ACC_W-1:0]     out_data,
  output logic                 busy,
  output logic                 err_sel
);

  state_e           r_state;
  logic [ACC_W-1:0] r_bank [NUM_BANKS];
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic [ACC_W-1:0] r_out_data;
  logic             r_busy;
  logic             r_err_sel;

  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_ok;
  logic             w_accept;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_bank0_nxt;
  logic [IDX_W-1:0] w_idx_inc;

  onehot_enc u_onehot_enc (
    .i_onehot    (sel_onehot),
    .o_idx       (w_sel_idx),
    .o_is_onehot (w_sel_ok)
  );

  assign in_ready = (r_state == ACCUM);
  assign w_accept = in_valid && in_ready;

`ifdef SUM_ACCUM_SAT_EN
  logic [ACC_W:0] w_add;
  assign w_add = {1'b0, r_bank[w_sel_idx]} + (ACC_W + 1)'(sum_in);
  assign w_sum = w_add[ACC_W] ? SAT_MAX[ACC_W-1:0] : w_add[ACC_W-1:0];
`else
  assign w_sum = r_bank[w_sel_idx] + ACC_W'(sum_in);
`endif

  // Bank 0 as it will be after this edge, so a same-cycle accept is visible in the first word.
  assign w_bank0_nxt = (w_accept && w_sel_ok && (w_sel_idx == '0)) ? w_sum : r_bank[0];
  assign w_idx_inc   = r_out_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_err_sel   <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) r_bank[i] <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_sel_ok) r_bank[w_sel_idx] <= w_sum;
            else          r_err_sel         <= 1'b1;
          end
          if (drain_req) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_out_idx   <= '0;
            r_out_data  <= w_bank0_nxt;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_out_idx == IDX_W'(NUM_BANKS - 1)) begin
              r_state     <= ACCUM;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_out_idx   <= '0;
              r_out_data  <= '0;
              for (int i = 0; i < NUM_BANKS; i++) r_bank[i] <= '0;
            end else begin
              r_out_idx  <= w_idx_inc;
              r_out_data <= r_bank[w_idx_inc];
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_sum_accum_bank.sv
// Directed plus randomized bench for sum_accum_bank against an arithmetic bank model.
module tb_sum_accum_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sum_in;
  logic [3:0] sel_onehot;
  logic       drain_req;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic [7:0] out_data;
  logic       busy;
  logic       err_sel;

  int total = 0;
  int bad   = 0;

  int model_bank [4];
  int model_err;

  always #5 clk = ~clk;

  sum_accum_bank #(.DATA_W(4), .ACC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .sel_onehot (sel_onehot),
    .drain_req  (drain_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .busy       (busy),
    .err_sel    (err_sel)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_bank[i] = 0;
  endtask

  task automatic model_accept(input int s, input logic [3:0] sel);
    int n;
    int idx;
    int t;
    n = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) begin n++; idx = i; end
    if (n != 1) begin
      model_err = 1;
    end else begin
      t = model_bank[idx] + s;
`ifdef SUM_ACCUM_SAT_EN
      model_bank[idx] = (t > 255) ? 255 : t;
`else
      model_bank[idx] = t % 256;
`endif
    end
  endtask

  task automatic send(input int s, input logic [3:0] sel);
    chk("in_ready_accum", in_ready, 1);
    in_valid = 1; sum_in = 4'(s); sel_onehot = sel;
    step();
    in_valid = 0;
    model_accept(s, sel);
  endtask

  // Drain all banks, stalling for `stalls` cycles on word `stall_idx`; optionally
  // present an accepted sum of 4 on bank 3 alongside the drain request.
  task automatic do_drain(input int stall_idx, input int stalls, input bit with_input);
    if (with_input) begin
      in_valid = 1; sum_in = 4'd4; sel_onehot = 4'b1000;
      model_accept(4, 4'b1000);
    end
    drain_req = 1; out_ready = 0;
    step();
    drain_req = 0; in_valid = 0;
    chk("busy_drain", busy, 1);
    chk("in_ready_drain", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_idx) begin
        for (int s = 0; s < stalls; s++) begin
          out_ready = 0; drain_req = 1;
          in_valid = 1; sum_in = 4'($urandom); sel_onehot = 4'b0001;
          chk("stall_valid", out_valid, 1);
          chk("stall_idx", out_idx, k);
          chk("stall_data", out_data, model_bank[k]);
          chk("stall_in_ready", in_ready, 0);
          step();
        end
        in_valid = 0; drain_req = 0;
      end
      out_ready = 1;
      chk("drain_valid", out_valid, 1);
      chk("drain_idx", out_idx, k);
      chk("drain_data", out_data, model_bank[k]);
      step();
    end
    out_ready = 0;
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_err", err_sel, model_err);
    model_clear();
  endtask

  initial begin
    logic [3:0] sel;
    rst = 1; in_valid = 0; sum_in = 0; sel_onehot = 0; drain_req = 0; out_ready = 0;
    model_clear();
    model_err = 0;

    // 1: reset then idle drain
    step(); step();
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sel, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_data", out_data, 0);
    do_drain(-1, 0, 0);

    // 2: basic accumulation, back-to-back drain
    send(3, 4'b0001); send(5, 4'b0100); send(15, 4'b0100);
    do_drain(-1, 0, 0);
    do_drain(-1, 0, 0);

    // 3: backpressure on word 2 with an ignored input and drain request
    send(9, 4'b0100); send(6, 4'b0010);
    do_drain(2, 3, 0);

    // 4: bad selects
    send(1, 4'b0001);
    send(7, 4'b0110); send(2, 4'b0000);
    chk("err_set", err_sel, 1);
    do_drain(-1, 0, 0);
    chk("err_sticky", err_sel, 1);

    // 5: overflow into bank 3
    for (int i = 0; i < 18; i++) send(15, 4'b1000);
    do_drain(-1, 0, 0);

    // 6: simultaneous accept and drain request
    send(2, 4'b0001);
    do_drain(-1, 0, 1);

    // reset mid-drain
    send(11, 4'b0010);
    drain_req = 1; step(); drain_req = 0;
    out_ready = 1; step(); out_ready = 0;
    chk("mid_idx", out_idx, 1);
    rst = 1; step(); rst = 0;
    model_clear(); model_err = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_sel, 0);
    step();
    chk("mid_rst_quiet", out_valid, 0);
    do_drain(-1, 0, 0);

    // randomized traffic
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 12; j++) begin
        sel = 4'b0001 << $urandom_range(3);
        if ($urandom_range(15) == 0) sel = 4'($urandom);
        send(int'($urandom_range(15)), sel);
      end
      do_drain(int'($urandom_range(4)), int'($urandom_range(3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_accum_bank.md
Name: sum_accum_bank

Overview:
Downstream stage of the 4-bit adder / 2-to-4 decoder block. Consumes its 4-bit sum and 4-bit one-hot decoder output. Accumulates each sum into one of four accumulator banks selected by the one-hot word. On request, drains the four bank totals serially over a valid/ready output port, then clears the banks.

Parameters:
DATA_W, 4, width of incoming sum (matches adder output)
ACC_W, 8, width of each accumulator bank; must be >= DATA_W
NUM_BANKS, 4, bank count; fixed to decoder output width, not to be overridden

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  sum_in/sel_onehot valid this cycle
in_ready  out  1  block accepts input this cycle
sum_in  in  DATA_W  sum from adder stage
sel_onehot  in  NUM_BANKS  one-hot bank select from decoder stage
drain_req  in  1  single-cycle pulse: start drain of all banks
out_valid  out  1  out_idx/out_data valid
out_ready  in  1  consumer accepts output
out_idx  out  2  bank index being presented
out_data  out  ACC_W  bank total being presented
busy  out  1  high while in DRAIN
err_sel  out  1  sticky: a non-one-hot select was accepted

Behaviour:
- Reset (rst=1 at clk edge): state=ACCUM, all banks=0, out_valid=0, out_idx=0, out_data=0, busy=0, err_sel=0; in_ready=1 from the next cycle. Reset mid-drain abandons the drain; no further out_valid.
- States: ACCUM, DRAIN.
- ACCUM: in_ready=1, out_valid=0, busy=0.
- Accept: in_valid && in_ready at an edge.
  - Exactly one bit of sel_onehot set: bank[idx] <= bank[idx] + zero-extended sum_in, modulo 2^ACC_W.
  - Zero or more than one bit set: no bank changes; err_sel <= 1 (sticky until rst).
- Latency: an accepted sum is visible in its bank one cycle later.
- drain_req in ACCUM: go to DRAIN next cycle.
  - An input accepted in the same cycle is accumulated first and is included in the drain.
- DRAIN: in_ready=0, busy=1, out_valid=1.
  - out_idx starts at 0; out_data=bank[out_idx], registered and stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_idx increments.
  - After the handshake at out_idx=3: all banks <= 0, out_idx <= 0, out_valid <= 0, state <= ACCUM.
- drain_req while in DRAIN: ignored, not queued.
- in_valid while in DRAIN: not accepted; the upstream holds.
- Back-to-back: out_ready held high drains 4 words in 4 consecutive cycles; ACCUM resumes on the 5th.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
Macro SUM_ACCUM_SAT_EN.
- Defined: bank addition saturates at 2^ACC_W-1, e.g. 8'hFD + 4'h5 = 8'hFF.
- Undefined: addition wraps modulo 2^ACC_W, e.g. 8'hFD + 4'h5 = 8'h02.
- All other behaviour is identical.

Decomposition:
- Package sum_accum_pkg holds:
  - state enum {ACCUM, DRAIN}
  - NUM_BANKS=4 and IDX_W=2 constants
  - saturation max constant
- One sub-module: onehot_enc. Combinational; maps NUM_BANKS one-hot to IDX_W index plus an is_onehot flag. Instantiated once on sel_onehot.
- Bank array and FSM stay in the top module.

Test Plan:
1. Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, busy=0, err_sel=0. A drain then returns 0,0,0,0 on idx 0..3.
2. Accumulate: sums 3,5,15 with sel=0001,0100,0100, then drain_req, out_ready=1 -> outputs (idx,data) = (0,3),(1,0),(2,20),(3,0) on 4 consecutive cycles. Banks are 0 after the drain.
3. Backpressure: drain with out_ready low for 3 cycles on idx 2 -> out_idx=2 and out_data stay stable, in_ready=0. An in_valid pulse during the drain is not accepted.
4. Bad select: sum 7 with sel=0110, then sum 2 with sel=0000 -> no bank changes, err_sel=1. err_sel stays 1 through a full drain and clears only on rst.
5. Overflow: 18 accepts of 15 into bank 3 (total 270) -> drain shows idx3 = 8'h0E without SUM_ACCUM_SAT_EN, 8'hFF with it.
6. Simultaneous/reset: drain_req in the same cycle as an accepted sum 4 on sel=1000 -> idx3 = 4. A second drain with rst asserted at idx 1 -> out_valid=0 next cycle, and a following drain returns all zeros.
